// File: rtl/addsub_flags_pipe_if.sv
// rtl/addsub_flags_pipe_if.sv - operand/result handshake bundle for addsub_flags_pipe
interface addsub_flags_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             set_flags;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       res_nzcv;
   logic             err;
   logic [3:0]       flags_nzcv;

   modport master (
      output in_valid, op, a, b, set_flags, sat, out_ready,
      input  in_ready, out_valid, result, res_nzcv, err, flags_nzcv
   );

   modport slave (
      input  in_valid, op, a, b, set_flags, sat, out_ready,
      output in_ready, out_valid, result, res_nzcv, err, flags_nzcv
   );
endinterface

// File: rtl/addsub_flags_pipe.sv
// rtl/addsub_flags_pipe.sv - pipelined add/sub unit with NZCV flag register
// Optional saturation on signed overflow is compiled in with ADDSUB_SAT_EN.
module addsub_flags_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic               clk,
   input logic               rst_n,
   addsub_flags_pipe_if.slave bus
);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_RSB = 3'b010;
   localparam logic [2:0] OP_ADC = 3'b011;
   localparam logic [2:0] OP_SBC = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;

   logic             w_adv;
   logic             w_acc;
   logic             w_rsvd;
   logic             w_wr_flags;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_c;
   logic             w_v;
   logic [WIDTH-1:0] w_res;
   logic [3:0]       w_nzcv;

   logic             r_vld  [STAGES];
   logic [WIDTH-1:0] r_res  [STAGES];
   logic [3:0]       r_nzcv [STAGES];
   logic             r_err  [STAGES];
   logic [3:0]       r_flags;

   // The whole pipe moves as one; bubbles are carried, never squeezed out.
   assign w_adv      = !r_vld[STAGES-1] || bus.out_ready;
   assign w_acc      = bus.in_valid && w_adv;
   assign w_rsvd     = bus.op[2] && bus.op[1];
   assign w_wr_flags = w_acc && !w_rsvd && (bus.set_flags || (bus.op == OP_CMP));

   always_comb begin
      w_x   = bus.a;
      w_y   = bus.b;
      w_cin = 1'b0;
      case (bus.op)
         OP_ADD: w_cin = 1'b0;
         OP_SUB, OP_CMP: begin
            w_y   = ~bus.b;
            w_cin = 1'b1;
         end
         OP_RSB: begin
            w_x   = bus.b;
            w_y   = ~bus.a;
            w_cin = 1'b1;
         end
         OP_ADC: w_cin = r_flags[1];
         OP_SBC: begin
            w_y   = ~bus.b;
            w_cin = r_flags[1];
         end
         default: w_cin = 1'b0;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
   assign w_c   = w_sum[WIDTH];
   assign w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
   // On overflow the true sign is the common sign of the two addends.
   always_comb begin
      w_res = w_sum[WIDTH-1:0];
      if (bus.sat && w_v) begin
         w_res = w_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   logic w_unused_sat;
   assign w_unused_sat = bus.sat;
   assign w_res        = w_sum[WIDTH-1:0];
`endif

   assign w_nzcv = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_vld[i]  <= 1'b0;
            r_res[i]  <= '0;
            r_nzcv[i] <= 4'b0000;
            r_err[i]  <= 1'b0;
         end
      end else if (w_adv) begin
         r_vld[0]  <= w_acc;
         r_res[0]  <= (w_acc && !w_rsvd) ? w_res : '0;
         r_nzcv[0] <= (w_acc && !w_rsvd) ? w_nzcv : 4'b0000;
         r_err[0]  <= w_acc && w_rsvd;
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_res[i]  <= r_res[i-1];
            r_nzcv[i] <= r_nzcv[i-1];
            r_err[i]  <= r_err[i-1];
         end
      end
   end

   // Flags commit at accept so a following ADC/SBC sees this carry directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 4'b0000;
      end else if (w_wr_flags) begin
         r_flags <= w_nzcv;
      end
   end

   assign bus.in_ready   = w_adv;
   assign bus.out_valid  = r_vld[STAGES-1];
   assign bus.result     = r_res[STAGES-1];
   assign bus.res_nzcv   = r_nzcv[STAGES-1];
   assign bus.err        = r_err[STAGES-1];
   assign bus.flags_nzcv = r_flags;
endmodule

// File: tb/tb_addsub_flags_pipe.sv
// tb/tb_addsub_flags_pipe.sv - directed-vector bench for addsub_flags_pipe
module tb_addsub_flags_pipe;
   localparam int WIDTH  = 32;
   localparam int STAGES = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_mis = 0;

   addsub_flags_pipe_if #(.WIDTH(WIDTH)) bus ();

   addsub_flags_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sf, input logic sat);
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.set_flags = sf;
      bus.sat       = sat;
   endtask

   task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf, input logic sat,
                         input logic [31:0] er, input logic [3:0] en, input logic ee,
                         input logic [3:0] ef);
      int lat;
      @(negedge clk);
      drive(op, a, b, sf, sat);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      check({tag, "_flags"}, bus.flags_nzcv, ef);
      while (!bus.out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_lat"}, lat, STAGES);
      check({tag, "_res"}, bus.result, er);
      check({tag, "_nzcv"}, bus.res_nzcv, en);
      check({tag, "_err"}, bus.err, ee);
   endtask

   initial begin
      logic [31:0] exp_q [6];
      int          ni;
      int          no;

      bus.in_valid  = 1'b0;
      bus.op        = 3'b000;
      bus.a         = '0;
      bus.b         = '0;
      bus.set_flags = 1'b0;
      bus.sat       = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_nzcv", bus.res_nzcv, 0);
      check("rst_err", bus.err, 0);
      check("rst_flags", bus.flags_nzcv, 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", bus.in_ready, 1);

      single("t1_sub", 3'b001, 32'd1, 32'd1, 1'b1, 1'b0, 32'h0, 4'b0110, 1'b0, 4'b0110);
      single("t2_sub_ovf", 3'b001, 32'h0, 32'h8000_0000, 1'b0, 1'b0,
             32'h8000_0000, 4'b1001, 1'b0, 4'b0110);
      single("t2_sub_pos", 3'b001, 32'h70, 32'h0C, 1'b0, 1'b0, 32'h64, 4'b0010, 1'b0, 4'b0110);

      // ADD sets C, ADC accepted on the very next edge consumes it.
      @(negedge clk);
      drive(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
      @(negedge clk);
      check("t3_flags", bus.flags_nzcv, 4'b0110);
      drive(3'b011, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t3_add_valid", bus.out_valid, 1);
      check("t3_add_res", bus.result, 32'h0);
      check("t3_add_nzcv", bus.res_nzcv, 4'b0110);
      @(negedge clk);
      check("t3_adc_valid", bus.out_valid, 1);
      check("t3_adc_res", bus.result, 32'h1);
      check("t3_adc_nzcv", bus.res_nzcv, 4'b0000);

      single("t5_rsvd", 3'b110, 32'h5, 32'h3, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b1, 4'b0110);
      check("t5_rsvd_flags", bus.flags_nzcv, 4'b0110);
      single("t5_cmp_lt", 3'b101, 32'd3, 32'd5, 1'b0, 1'b0,
             32'hFFFF_FFFE, 4'b1000, 1'b0, 4'b1000);
      single("t5_cmp_eq", 3'b101, 32'd3, 32'd3, 1'b0, 1'b0, 32'h0, 4'b0110, 1'b0, 4'b0110);
      single("t5_rsb", 3'b010, 32'd2, 32'd9, 1'b0, 1'b0, 32'd7, 4'b0010, 1'b0, 4'b0110);

`ifdef ADDSUB_SAT_EN
      single("t6_sat", 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 4'b0001, 1'b0, 4'b0110);
`else
      single("t6_sat", 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
             32'h8000_0000, 4'b1001, 1'b0, 4'b0110);
`endif

      // Six SUB beats, consumer stalls for cycles 3..5.
      for (int i = 0; i < 6; i++) exp_q[i] = 32'hFF * (i + 1);
      ni = 0;
      no = 0;
      for (int t = 0; t < 24 && no < 6; t++) begin
         @(negedge clk);
         bus.out_ready = !(t >= 3 && t <= 5);
         #1;
         check("t4_in_ready", bus.in_ready, (t >= 3 && t <= 5) ? 0 : 1);
         if (bus.out_valid) begin
            check("t4_res", bus.result, exp_q[no]);
            check("t4_nzcv", bus.res_nzcv, 4'b0010);
            if (bus.out_ready) no++;
         end
         if (bus.in_ready && ni < 6) begin
            drive(3'b001, 32'h100 * (ni + 1), ni + 1, 1'b0, 1'b0);
            ni++;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      check("t4_count", no, 6);

      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(3'b001, 32'd5, 32'd3, 1'b1, 1'b0);
      @(negedge clk);
      drive(3'b001, 32'd9, 32'd4, 1'b1, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t4_pre_flags", bus.flags_nzcv, 4'b0010);
      check("t4_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", bus.out_valid, 0);
      check("t4_rst_flags", bus.flags_nzcv, 4'b0000);
      check("t4_rst_result", bus.result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_post_valid", bus.out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
